// File: rtl/mips_pkg.sv
// Shared types and constants for the mips lab SoC shell: ALU op encoding,
// data widths and the active-low 7-segment decoder.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int KEY_N  = 8;
    localparam int CNT_W  = 8;
    localparam int DIGITS = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_SLL   = 3'd5,
        OP_SRL   = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, decimal point kept off.
    function automatic logic [7:0] hex2seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mips_key_filter.sv
// One push-key input path: 2-flop synchronizer and a single-cycle accept pulse.
// MIPS_DEBOUNCE_EN selects the stable-run debouncer; otherwise a falling-edge detector.
module mips_key_filter #(
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic accept
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    assign sync_d = {sync_q[0], key_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef MIPS_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          pressed_q;
    logic          pressed_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter measures how long the pin has sat at the level opposite to
    // the current state; any sample back at the current level restarts it.
    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = '0;
        accept    = 1'b0;
        if (sync_q[1] == pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = ~pressed_q;
                accept    = ~pressed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end
`else
    logic prev_q;
    logic prev_d;

    assign prev_d = sync_q[1];
    assign accept = prev_q & ~sync_q[1] & (DEBOUNCE_CYC > 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end
`endif

endmodule

// File: rtl/mips.sv
// Board-level top: per-key filters, priority encoder, 32-bit ALU, result and
// press counter, and multiplexed 7-seg scan. Key path depends on MIPS_DEBOUNCE_EN.
module mips
    import mips_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic        clk_in,
    input  logic        sys_rstn,
    input  logic [7:0]  dip_switch0,
    input  logic [7:0]  dip_switch1,
    input  logic [7:0]  dip_switch2,
    input  logic [7:0]  dip_switch3,
    input  logic [7:0]  dip_switch4,
    input  logic [7:0]  dip_switch5,
    input  logic [7:0]  dip_switch6,
    input  logic [7:0]  dip_switch7,
    input  logic [7:0]  user_key,
    output logic [31:0] led_light,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1,
    output logic [7:0]  digital_tube2,
    output logic        digital_tube_sel2
);

    localparam int IW = $clog2(DIGITS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [KEY_N-1:0]  accept;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              op_valid;
    op_e               op;
    logic [DATA_W-1:0] alu_res;

    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;
    logic [DW-1:0]     div_q, div_d;
    logic [IW-1:0]     idx_q, idx_d;

    for (genvar k = 0; k < KEY_N; k++) begin : g_key
        mips_key_filter #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_filt (
            .clk    (clk_in),
            .rst    (sys_rstn),
            .key_n  (user_key[k]),
            .accept (accept[k])
        );
    end

    assign opa = ~{dip_switch3, dip_switch2, dip_switch1, dip_switch0};
    assign opb = ~{dip_switch7, dip_switch6, dip_switch5, dip_switch4};

    // Scanning from the top down leaves the lowest accepted key in op.
    always_comb begin
        op_valid = 1'b0;
        op       = OP_ADD;
        for (int i = KEY_N - 1; i >= 0; i--) begin
            if (accept[i]) begin
                op_valid = 1'b1;
                op       = op_e'(i[2:0]);
            end
        end
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SLL:  alu_res = opa << opb[4:0];
            OP_SRL:  alu_res = opa >> opb[4:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        result_d    = result_q;
        press_cnt_d = press_cnt_q;
        if (op_valid) begin
            if (op == OP_CLEAR) begin
                result_d    = '0;
                press_cnt_d = '0;
            end else begin
                result_d    = alu_res;
                press_cnt_d = press_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge sys_rstn) begin
        if (sys_rstn) begin
            result_q    <= '0;
            press_cnt_q <= '0;
            div_q       <= '0;
            idx_q       <= '0;
        end else begin
            result_q    <= result_d;
            press_cnt_q <= press_cnt_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
        end
    end

    // Tube1 shows the upper half-word, so its nibble sits 16 bits above tube0's.
    always_comb begin
        led_light         = ~result_q;
        digital_tube_sel0 = 4'b0001 << idx_q;
        digital_tube_sel1 = 4'b0001 << idx_q;
        digital_tube0     = hex2seg(result_q[4*idx_q +: 4]);
        digital_tube1     = hex2seg(result_q[16 + 4*idx_q +: 4]);
        digital_tube2     = hex2seg(press_cnt_q[3:0]);
        digital_tube_sel2 = 1'b1;
    end

endmodule

// File: tb/tb_mips.sv
// Self-checking bench for mips: directed key/ALU scenarios plus random key and
// switch activity, compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_mips;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic [7:0]  sw [8];
    logic [7:0]  key_n;
    logic [31:0] led_light;
    logic [7:0]  tube0, tube1, tube2;
    logic [3:0]  sel0, sel1;
    logic        sel2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // behavioural model state
    logic [31:0] m_res;
    logic [7:0]  m_cnt;
    int          m_tick;
    logic [7:0]  m_syn1, m_syn2, m_prev, m_armed;
    logic [31:0] m_hist [8];

    always #5 clk_in = ~clk_in;

    mips #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DB)) dut (
        .clk_in            (clk_in),
        .sys_rstn          (rst),
        .dip_switch0       (sw[0]),
        .dip_switch1       (sw[1]),
        .dip_switch2       (sw[2]),
        .dip_switch3       (sw[3]),
        .dip_switch4       (sw[4]),
        .dip_switch5       (sw[5]),
        .dip_switch6       (sw[6]),
        .dip_switch7       (sw[7]),
        .user_key          (key_n),
        .led_light         (led_light),
        .digital_tube0     (tube0),
        .digital_tube_sel0 (sel0),
        .digital_tube1     (tube1),
        .digital_tube_sel1 (sel1),
        .digital_tube2     (tube2),
        .digital_tube_sel2 (sel2)
    );

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_res = '0; m_cnt = '0; m_tick = 0;
        m_syn1 = 8'hFF; m_syn2 = 8'hFF; m_prev = 8'hFF; m_armed = 8'hFF;
        for (int i = 0; i < 8; i++) m_hist[i] = '1;
    endtask

    task automatic apply_op(input int k);
        logic [31:0] a, b;
        a = ~{sw[3], sw[2], sw[1], sw[0]};
        b = ~{sw[7], sw[6], sw[5], sw[4]};
        case (k)
            0: m_res = a + b;
            1: m_res = a - b;
            2: m_res = a & b;
            3: m_res = a | b;
            4: m_res = a ^ b;
            5: m_res = a << b[4:0];
            6: m_res = a >> b[4:0];
            default: m_res = '0;
        endcase
        if (k == 7) m_cnt = '0;
        else        m_cnt = m_cnt + 8'd1;
    endtask

    // One rising edge: the synced pin seen during the ending cycle decides the accept.
    task automatic model_edge();
        logic [7:0]  acc;
        logic [31:0] mask;
        bit          done;
        mask = (32'd1 << DB) - 32'd1;
        acc  = '0;
        for (int i = 0; i < 8; i++) begin
            m_hist[i] = {m_hist[i][30:0], m_syn2[i]};
`ifdef MIPS_DEBOUNCE_EN
            if (m_armed[i] && (m_hist[i] & mask) == 32'd0) begin
                acc[i] = 1'b1;
                m_armed[i] = 1'b0;
            end else if (!m_armed[i] && (m_hist[i] & mask) == mask) begin
                m_armed[i] = 1'b1;
            end
`else
            acc[i] = m_prev[i] & ~m_syn2[i];
`endif
        end
        m_prev = m_syn2;
        done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (acc[i] && !done) begin
                apply_op(i);
                done = 1'b1;
            end
        end
        m_syn2 = m_syn1;
        m_syn1 = key_n;
        m_tick++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            if (!rst) model_edge();
            #1;
        end
    endtask

    task automatic press(input logic [7:0] mask_n, input int low_cyc, input int high_cyc);
        key_n = mask_n;
        tick(low_cyc);
        key_n = 8'hFF;
        tick(high_cyc);
    endtask

    always @(negedge clk_in) begin
        if (chk_on) begin
            int idx;
            idx = (m_tick / SD) % 4;
            chk("led_light", led_light, ~m_res);
            chk("sel0", {28'd0, sel0}, 32'd1 << idx);
            chk("sel1", {28'd0, sel1}, 32'd1 << idx);
            chk("tube0", {24'd0, tube0}, {24'd0, seg_of(m_res[4*idx +: 4])});
            chk("tube1", {24'd0, tube1}, {24'd0, seg_of(m_res[16 + 4*idx +: 4])});
            chk("tube2", {24'd0, tube2}, {24'd0, seg_of(m_cnt[3:0])});
            chk("sel2", {31'd0, sel2}, 32'd1);
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) sw[i] = 8'hFF;
        key_n = 8'hFF;
        rst   = 1'b1;
        model_reset();
        tick(300);
        chk_on = 1'b1;
        chk("rst_led", led_light, 32'hFFFF_FFFF);
        chk("rst_tube0", {24'd0, tube0}, 32'hC0);
        chk("rst_tube1", {24'd0, tube1}, 32'hC0);
        chk("rst_tube2", {24'd0, tube2}, 32'hC0);
        chk("rst_sel0", {28'd0, sel0}, 32'h1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("scan_sel0", {28'd0, sel0}, 32'd1 << k);
            tick(SD);
        end
        chk("scan_wrap", {28'd0, sel0}, 32'h1);

        // ADD 5+3
        sw[0] = ~8'h05; sw[4] = ~8'h03;
        press(8'hFE, 5, 10);
        chk("model_add", m_res, 32'd8);
        chk("add_led", led_light, 32'hFFFF_FFF7);
        chk("add_tube2", {24'd0, tube2}, 32'hF9);

        // SUB 5-3, then 3-5
        press(8'hFD, 5, 10);
        chk("sub_led", led_light, 32'hFFFF_FFFD);
        sw[0] = ~8'h03; sw[4] = ~8'h05;
        press(8'hFD, 5, 10);
        chk("model_sub", m_res, 32'hFFFF_FFFE);
        chk("sub_neg_led", led_light, 32'h0000_0001);
        for (int k = 0; k < 4; k++) begin
            chk("tube1_F", {24'd0, tube1}, 32'h8E);
            tick(SD);
        end

        // Short key0 glitch
        press(8'hFE, 2, 10);
`ifdef MIPS_DEBOUNCE_EN
        chk("glitch_led", led_light, 32'h0000_0001);
        chk("glitch_tube2", {24'd0, tube2}, 32'hB0);
`else
        chk("glitch_led", led_light, 32'hFFFF_FFF7);
        chk("glitch_tube2", {24'd0, tube2}, 32'h99);
`endif

        // Keys 0 and 2 together: ADD wins (AND would give 1)
        sw[0] = ~8'h05; sw[4] = ~8'h03;
        press(8'hFA, 5, 10);
        chk("prio_led", led_light, 32'hFFFF_FFF7);
`ifdef MIPS_DEBOUNCE_EN
        chk("prio_tube2", {24'd0, tube2}, 32'h99);
`else
        chk("prio_tube2", {24'd0, tube2}, 32'h92);
`endif

        // CLEAR, nine ADDs, CLEAR
        press(8'h7F, 5, 10);
        chk("clr_led", led_light, 32'hFFFF_FFFF);
        repeat (9) press(8'hFE, 5, 10);
        chk("nine_tube2", {24'd0, tube2}, 32'h90);
        chk("model_cnt9", {24'd0, m_cnt}, 32'd9);
        press(8'h7F, 5, 10);
        chk("clr2_led", led_light, 32'hFFFF_FFFF);
        chk("clr2_tube2", {24'd0, tube2}, 32'hC0);

        // OR, then reset in the middle of a key0 press
        press(8'hF7, 5, 10);
        chk("or_led", led_light, ~32'h7);
        key_n = 8'hFE;
        tick(2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_led", led_light, 32'hFFFF_FFFF);
        chk("mid_rst_tube2", {24'd0, tube2}, 32'hC0);
        chk("mid_rst_sel0", {28'd0, sel0}, 32'h1);
        tick(3);
        rst = 1'b0;
        tick(10);
        key_n = 8'hFF;
        tick(10);
        chk("held_after_rst", led_light, 32'hFFFF_FFF7);

        // Random key and switch activity
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 7) == 0) key_n[i] = ~key_n[i];
            if ($urandom_range(0, 15) == 0) sw[$urandom_range(0, 7)] = 8'($urandom);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
